// File: rtl/t5_lsu.sv
// Load/store unit: turns one execute-stage load or store into a single Wishbone data cycle.
//
// Ports:
//   sclk, srst          clock (rising edge), asynchronous active-low reset
//   sena, dval          request qualifiers (sampled in idle only)
//   dopc, dfn3          opcode (load/store) and funct3 (size, unsigned)
//   dadr, ddat          effective byte address, right-justified store data
//   dwb_*               Wishbone data master (adr/dto/sel/stb/wre out, dti/ack in)
//   xstall              pipeline hold while a bus cycle is outstanding
//   xrdat, xrdv         extended load result and its one-cycle valid
//   xmis, xerr          one-cycle pulses: misaligned/illegal access, bus timeout
module t5_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TOUT = 255
) (
  input  logic                         sclk,
  input  logic                         srst,
  input  logic                         sena,
  input  logic                         dval,
  input  logic [6:2]                   dopc,
  input  logic [14:12]                 dfn3,
  input  logic [XLEN-1:0]              dadr,
  input  logic [XLEN-1:0]              ddat,
  output logic [XLEN-1:$clog2(XLEN/8)] dwb_adr,
  output logic [XLEN-1:0]              dwb_dto,
  output logic [XLEN/8-1:0]            dwb_sel,
  output logic                         dwb_stb,
  output logic                         dwb_wre,
  input  logic [XLEN-1:0]              dwb_dti,
  input  logic                         dwb_ack,
  output logic                         xstall,
  output logic [XLEN-1:0]              xrdat,
  output logic                         xrdv,
  output logic                         xmis,
  output logic                         xerr
);

  localparam int unsigned NL = XLEN / 8;
  localparam int unsigned AL = $clog2(NL);
  localparam int unsigned CW = (TOUT > 1) ? $clog2(TOUT + 1) : 1;
  localparam logic [4:0]  OpLoad  = 5'b00000;
  localparam logic [4:0]  OpStore = 5'b01000;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:AL]    adr_q, adr_d;
  logic [XLEN-1:0]     dto_q, dto_d;
  logic [NL-1:0]       sel_q, sel_d;
  logic                wre_q, wre_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [AL-1:0]       off_q, off_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     rdat_q, rdat_d;
  logic                rdv_q, rdv_d;
  logic                mis_q, mis_d;
  logic                err_q, err_d;

  logic [1:0]          size;
  logic [AL-1:0]       off;
  logic                is_req;
  logic                illegal;
  logic [7:0]          align_mask;
  logic [7:0]          size_mask;
  logic [15:0]         sel_wide;
  logic [XLEN-1:0]     dto_rep;
  logic [XLEN-1:0]     ld_shift;
  logic [XLEN-1:0]     ld_ext;
  logic                fill;
  int                  ld_width;

  assign size   = dfn3[13:12];
  assign off    = dadr[AL-1:0];
  assign is_req = sena && dval && (dopc == OpLoad || dopc == OpStore);

  // Request-side decode: alignment, lane selects and replicated store data.
  always_comb begin
    align_mask = 8'h00;
    size_mask  = 8'h01;
    unique case (size)
      2'd0: begin align_mask = 8'h00; size_mask = 8'h01; end
      2'd1: begin align_mask = 8'h01; size_mask = 8'h03; end
      2'd2: begin align_mask = 8'h03; size_mask = 8'h0F; end
      default: begin align_mask = 8'h07; size_mask = 8'hFF; end
    endcase
    // Doublewords do not exist on a 32-bit bus.
    illegal  = (|(8'(off) & align_mask)) || (size == 2'd3 && XLEN == 32);
    sel_wide = {8'h00, size_mask} << off;
    dto_rep  = '0;
    for (int i = 0; i < int'(NL); i++) begin
      case (size)
        2'd0:    dto_rep[8*i +: 8] = ddat[7:0];
        2'd1:    dto_rep[8*i +: 8] = ddat[8*(i%2) +: 8];
        2'd2:    dto_rep[8*i +: 8] = ddat[8*(i%4) +: 8];
        default: dto_rep[8*i +: 8] = ddat[8*i +: 8];
      endcase
    end
  end

  // Load alignment and extension; a word on a 32-bit bus is already full width.
  assign ld_shift = dwb_dti >> {off_q, 3'b000};

  always_comb begin
    ld_width = int'(XLEN);
    fill     = 1'b0;
    case (size_q)
      2'd0:    begin ld_width = 8;  fill = ~uns_q & ld_shift[7];  end
      2'd1:    begin ld_width = 16; fill = ~uns_q & ld_shift[15]; end
      2'd2:    begin ld_width = 32; fill = ~uns_q & ld_shift[31]; end
      default: begin ld_width = int'(XLEN); fill = 1'b0; end
    endcase
    ld_ext = ld_shift;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i >= ld_width) ld_ext[i] = fill;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dto_d   = dto_q;
    sel_d   = sel_q;
    wre_d   = wre_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    rdv_d   = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_req) begin
          if (illegal) begin
            mis_d = 1'b1;
          end else begin
            state_d = StBusy;
            adr_d   = dadr[XLEN-1:AL];
            dto_d   = dto_rep;
            sel_d   = sel_wide[NL-1:0];
            wre_d   = dopc[5];
            size_d  = size;
            uns_d   = dfn3[14];
            off_d   = off;
            cnt_d   = '0;
          end
        end
      end
      StBusy: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (dwb_ack) begin
          state_d = StIdle;
          if (!wre_q) begin
            rdat_d = ld_ext;
            rdv_d  = 1'b1;
          end
        end else if (TOUT != 0 && (32'(cnt_q) + 32'd1) == TOUT) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      dto_q   <= '0;
      sel_q   <= '0;
      wre_q   <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      rdv_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dto_q   <= dto_d;
      sel_q   <= sel_d;
      wre_q   <= wre_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      rdv_q   <= rdv_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign dwb_stb = (state_q == StBusy);
  assign xstall  = (state_q == StBusy);
  assign dwb_adr = adr_q;
  assign dwb_dto = dto_q;
  assign dwb_sel = sel_q;
  assign dwb_wre = wre_q;
  assign xrdat   = rdat_q;
  assign xrdv    = rdv_q;
  assign xmis    = mis_q;
  assign xerr    = err_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Bench for t5_lsu: a 32-bit and a 64-bit instance (both TOUT=4) exercised one at a time.
// Load results are predicted when a load is issued and matched when xrdv fires.
module tb_t5_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, sena, dval32, dval64, ack32, ack64;
  logic [4:0]  dopc;
  logic [2:0]  dfn3;
  logic [63:0] dadr, ddat, dti;

  logic [31:2] adr32;
  logic [31:0] dto32, rdat32;
  logic [3:0]  sel32;
  logic        stb32, wre32, stall32, rdv32, mis32, err32;

  logic [63:3] adr64;
  logic [63:0] dto64, rdat64;
  logic [7:0]  sel64;
  logic        stb64, wre64, stall64, rdv64, mis64, err64;

  t5_lsu #(.XLEN(32), .TOUT(4)) u_dut32 (
    .sclk(clk), .srst(srst), .sena(sena), .dval(dval32), .dopc(dopc), .dfn3(dfn3),
    .dadr(dadr[31:0]), .ddat(ddat[31:0]), .dwb_adr(adr32), .dwb_dto(dto32), .dwb_sel(sel32),
    .dwb_stb(stb32), .dwb_wre(wre32), .dwb_dti(dti[31:0]), .dwb_ack(ack32), .xstall(stall32),
    .xrdat(rdat32), .xrdv(rdv32), .xmis(mis32), .xerr(err32)
  );

  t5_lsu #(.XLEN(64), .TOUT(4)) u_dut64 (
    .sclk(clk), .srst(srst), .sena(sena), .dval(dval64), .dopc(dopc), .dfn3(dfn3),
    .dadr(dadr), .ddat(ddat), .dwb_adr(adr64), .dwb_dto(dto64), .dwb_sel(sel64),
    .dwb_stb(stb64), .dwb_wre(wre64), .dwb_dti(dti), .dwb_ack(ack64), .xstall(stall64),
    .xrdat(rdat64), .xrdv(rdv64), .xmis(mis64), .xerr(err64)
  );

  localparam logic [4:0] OpLd = 5'b00000;
  localparam logic [4:0] OpSt = 5'b01000;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  logic [63:0] exp32_q[$];
  logic [63:0] exp64_q[$];

  always @(negedge clk) begin
    if (rdv32 === 1'b1) begin
      check_eq("rdv32_expected", 64'(exp32_q.size() != 0), 64'd1);
      if (exp32_q.size() != 0) check_eq("rdat32", {32'h0, rdat32}, exp32_q.pop_front());
    end
    if (rdv64 === 1'b1) begin
      check_eq("rdv64_expected", 64'(exp64_q.size() != 0), 64'd1);
      if (exp64_q.size() != 0) check_eq("rdat64", rdat64, exp64_q.pop_front());
    end
  end

  typedef struct {
    logic [63:0] sel, dto, adr;
    logic        wre;
    int          stb_n, rdv_n, mis_n, err_n, rdv_at, err_at, mis_at;
  } obs_t;

  // Called just after a rising edge. Issues one request, then watches 10 cycles;
  // ack is driven during BUSY cycle ack_at (1-based), 0 means never.
  task automatic txn(input bit is64, input bit en, input logic [4:0] opc, input logic [2:0] f3,
                     input logic [63:0] adr, input logic [63:0] dat, input logic [63:0] rd,
                     input int ack_at, output obs_t ob);
    ob = '{default: 0};
    sena = en; dopc = opc; dfn3 = f3; dadr = adr; ddat = dat; dti = rd;
    dval32 = !is64; dval64 = is64;
    @(posedge clk); #1;
    dval32 = 1'b0; dval64 = 1'b0; sena = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      ack32 = !is64 && (c == ack_at);
      ack64 = is64 && (c == ack_at);
      @(negedge clk);
      if (c == 1) begin
        ob.sel = is64 ? 64'(sel64) : 64'(sel32);
        ob.dto = is64 ? dto64 : 64'(dto32);
        ob.adr = is64 ? 64'(adr64) : 64'(adr32);
        ob.wre = is64 ? wre64 : wre32;
      end
      if (is64 ? stb64 : stb32) ob.stb_n++;
      if (is64 ? rdv64 : rdv32) begin ob.rdv_n++; if (ob.rdv_at == 0) ob.rdv_at = c; end
      if (is64 ? mis64 : mis32) begin ob.mis_n++; if (ob.mis_at == 0) ob.mis_at = c; end
      if (is64 ? err64 : err32) begin ob.err_n++; if (ob.err_at == 0) ob.err_at = c; end
      @(posedge clk); #1;
    end
    ack32 = 1'b0; ack64 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t ob;
    srst = 1'b1; sena = 1'b0; dval32 = 1'b0; dval64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
    dopc = 5'b11111; dfn3 = 3'b0; dadr = '0; ddat = '0; dti = '0;
    #2 srst = 1'b0;
    #2;
    check_eq("rst_stb32", stb32, 0);
    check_eq("rst_stall32", stall32, 0);
    check_eq("rst_sel32", sel32, 0);
    check_eq("rst_adr32", adr32, 0);
    check_eq("rst_dto32", dto32, 0);
    check_eq("rst_wre32", wre32, 0);
    check_eq("rst_pulses32", {rdv32, mis32, err32}, 0);
    check_eq("rst_rdat32", rdat32, 0);
    check_eq("rst_stb64", stb64, 0);
    check_eq("rst_rdat64", rdat64, 0);
    repeat (2) @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk); #1;

    // LB, sign-extended
    exp32_q.push_back(64'hFFFF_FF80);
    txn(0, 1, OpLd, 3'b000, 64'h1003, 64'h0, 64'h80FF_FF00, 1, ob);
    check_eq("lb_sel", ob.sel, 64'h8);
    check_eq("lb_adr", ob.adr, 64'h400);
    check_eq("lb_wre", ob.wre, 0);
    check_eq("lb_stb_n", ob.stb_n, 1);
    check_eq("lb_rdv_n", ob.rdv_n, 1);
    check_eq("lb_rdv_at", ob.rdv_at, 2);

    // LBU
    exp32_q.push_back(64'h0000_0080);
    txn(0, 1, OpLd, 3'b100, 64'h1003, 64'h0, 64'h80FF_FF00, 1, ob);
    check_eq("lbu_rdv_n", ob.rdv_n, 1);

    // SH: replicated data, no load result
    txn(0, 1, OpSt, 3'b001, 64'h2002, 64'h1234_ABCD, 64'h0, 1, ob);
    check_eq("sh_sel", ob.sel, 64'hC);
    check_eq("sh_dto", ob.dto, 64'hABCD_ABCD);
    check_eq("sh_wre", ob.wre, 1);
    check_eq("sh_adr", ob.adr, 64'h800);
    check_eq("sh_rdv_n", ob.rdv_n, 0);

    // Misaligned LH and LD on a 32-bit bus
    txn(0, 1, OpLd, 3'b001, 64'h1001, 64'h0, 64'h0, 1, ob);
    check_eq("lh_mis_n", ob.mis_n, 1);
    check_eq("lh_mis_at", ob.mis_at, 1);
    check_eq("lh_stb_n", ob.stb_n, 0);
    txn(0, 1, OpLd, 3'b011, 64'h0, 64'h0, 64'h0, 1, ob);
    check_eq("ld32_mis_n", ob.mis_n, 1);
    check_eq("ld32_stb_n", ob.stb_n, 0);

    // Non-request opcode and disabled pipeline leave the unit idle
    txn(0, 1, 5'b01100, 3'b010, 64'h0, 64'h0, 64'h0, 1, ob);
    check_eq("nonreq_stb_n", ob.stb_n, 0);
    check_eq("nonreq_mis_n", ob.mis_n, 0);
    txn(0, 0, OpLd, 3'b010, 64'h0, 64'h0, 64'h0, 1, ob);
    check_eq("sena0_stb_n", ob.stb_n, 0);

    // Timeout: four strobe cycles, xerr in the fifth, result register untouched
    txn(0, 1, OpLd, 3'b010, 64'h3000, 64'h0, 64'h5555_5555, 0, ob);
    check_eq("to_stb_n", ob.stb_n, 4);
    check_eq("to_err_n", ob.err_n, 1);
    check_eq("to_err_at", ob.err_at, 5);
    check_eq("to_rdv_n", ob.rdv_n, 0);
    check_eq("to_rdat", rdat32, 64'h0000_0080);

    // Ack on the expiry cycle wins; unsigned flag ignored for a 32-bit word
    exp32_q.push_back(64'h9000_0001);
    txn(0, 1, OpLd, 3'b110, 64'h3000, 64'h0, 64'h9000_0001, 4, ob);
    check_eq("late_stb_n", ob.stb_n, 4);
    check_eq("late_err_n", ob.err_n, 0);
    check_eq("late_rdv_at", ob.rdv_at, 5);

    // 64-bit LW / LWU in the upper half
    exp64_q.push_back(64'hFFFF_FFFF_8765_4321);
    txn(1, 1, OpLd, 3'b010, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 1, ob);
    check_eq("lw64_sel", ob.sel, 64'hF0);
    check_eq("lw64_adr", ob.adr, 64'h200);
    check_eq("lw64_rdv_n", ob.rdv_n, 1);
    exp64_q.push_back(64'h0000_0000_8765_4321);
    txn(1, 1, OpLd, 3'b110, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 1, ob);
    check_eq("lwu64_rdv_n", ob.rdv_n, 1);

    // 64-bit LH at lane 6 and SD
    exp64_q.push_back(64'hFFFF_FFFF_FFFF_BEEF);
    txn(1, 1, OpLd, 3'b001, 64'h6, 64'h0, 64'hBEEF_0000_0000_0000, 2, ob);
    check_eq("lh64_sel", ob.sel, 64'hC0);
    check_eq("lh64_rdv_at", ob.rdv_at, 3);
    txn(1, 1, OpSt, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1, ob);
    check_eq("sd64_sel", ob.sel, 64'hFF);
    check_eq("sd64_dto", ob.dto, 64'h1122_3344_5566_7788);
    check_eq("sd64_wre", ob.wre, 1);
    check_eq("sd64_rdv_n", ob.rdv_n, 0);

    // Asynchronous reset while BUSY, then a stray ack, then a clean LW
    sena = 1'b1; dopc = OpLd; dfn3 = 3'b010; dadr = 64'h40; dval32 = 1'b1;
    @(posedge clk); #1 dval32 = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_stb_pre", stb32, 1);
    #2 srst = 1'b0;
    #1;
    check_eq("rst_busy_stb", stb32, 0);
    check_eq("rst_busy_stall", stall32, 0);
    check_eq("rst_busy_sel", sel32, 0);
    check_eq("rst_busy_adr", adr32, 0);
    check_eq("rst_busy_rdat", rdat32, 0);
    @(posedge clk); #1 srst = 1'b1;
    ack32 = 1'b1; dti = 64'hDEAD_BEEF;
    @(posedge clk); #1 ack32 = 1'b0;
    @(negedge clk);
    check_eq("stray_ack_stb", stb32, 0);
    check_eq("stray_ack_rdv", rdv32, 0);
    @(posedge clk); #1;
    exp32_q.push_back(64'hCAFE_F00D);
    txn(0, 1, OpLd, 3'b010, 64'h44, 64'h0, 64'hCAFE_F00D, 1, ob);
    check_eq("post_rst_sel", ob.sel, 64'hF);
    check_eq("post_rst_adr", ob.adr, 64'h11);
    check_eq("post_rst_rdv_n", ob.rdv_n, 1);

    check_eq("sb32_empty", exp32_q.size(), 0);
    check_eq("sb64_empty", exp64_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/t5_lsu.md
# t5_lsu

Parametrised load/store unit for the tra5 core, replacing the fixed 32-bit data-bus front end. It sits between the execute stage and the data Wishbone port. It accepts one load or store per request, drives lane selects and replicated store data, and holds the bus until `dwb_ack`. It extracts and sign/zero-extends load data, flags misaligned or illegal accesses, and aborts hung cycles with a timeout.

## Interface

Parameters:
- `XLEN`, 32: datapath width, 32 or 64; lanes `NL = XLEN/8`, offset bits `AL = log2(NL)`.
- `TOUT`, 255: bus timeout in BUSY cycles; 0 disables the timeout.

Ports:
- `sclk`  in  1  clock, all state on rising edge.
- `srst`  in  1  reset, asynchronous, active-low.
- `sena`  in  1  pipeline enable; qualifies request acceptance only.
- `dval`  in  1  request valid from execute.
- `dopc`  in  [6:2]  opcode; load = 5'b00000, store = 5'b01000, any other value is not a request.
- `dfn3`  in  [14:12]  funct3; [13:12] size (0 B, 1 H, 2 W, 3 D); [14] unsigned load.
- `dadr`  in  XLEN  effective byte address.
- `ddat`  in  XLEN  store data, right-justified.
- `dwb_adr`  out  [XLEN-1:AL]  word address.
- `dwb_dto`  out  XLEN  store data.
- `dwb_sel`  out  NL  byte-lane select.
- `dwb_stb`  out  1  bus strobe.
- `dwb_wre`  out  1  write enable.
- `dwb_dti`  in  XLEN  read data.
- `dwb_ack`  in  1  bus acknowledge.
- `xstall`  out  1  pipeline hold.
- `xrdat`  out  XLEN  extended load result.
- `xrdv`  out  1  load result valid, one-cycle pulse.
- `xmis`  out  1  misaligned/illegal access, one-cycle pulse.
- `xerr`  out  1  bus timeout, one-cycle pulse.

## Operation

- States: IDLE, BUSY.
- Accept in IDLE when `sena & dval` and `dopc` is a load or store. Any other `dopc`, or `dval`/`sena` low, leaves the block idle.
- Offset `o = dadr[AL-1:0]`. The access is illegal when:
  - size H with `o[0]`;
  - size W with `o[1:0]` non-zero;
  - size D with `o[2:0]` non-zero;
  - size D when `XLEN=32`.
- Illegal accepted access: stay IDLE, pulse `xmis` next cycle, no bus cycle.
- Legal accepted access: register the address, `dwb_wre = dopc[5]`, size, unsigned flag and `o`; go to BUSY.
  - `dwb_sel` = size mask (B 0x1, H 0x3, W 0xF, D 0xFF) shifted left by `o`, truncated to NL.
  - `dwb_dto` = the low 2^size bytes of `ddat` replicated across all lanes.
- BUSY: `dwb_stb`=1 and all bus outputs are held stable.
  - On `dwb_ack`: return to IDLE. For a load, register `xrdat` and pulse `xrdv`.
  - `xrdat` = `dwb_dti` shifted right by 8·o, then truncated to the size and sign-extended (`dfn3[14]`=0) or zero-extended (=1).
  - W on XLEN=32 is full width and ignores `dfn3[14]`.
  - Stores produce no `xrdv`.
- Timeout: a counter clears on entry to BUSY and increments each BUSY cycle without ack. If it reaches TOUT with no ack, return to IDLE, drop `dwb_stb`, pulse `xerr`, and leave `xrdat` unchanged. Ack on the expiry cycle wins over the timeout.
- `dwb_ack` in IDLE is ignored.
- `sena` is not sampled in BUSY.
- `xstall` = 1 in BUSY (registered state), 0 in IDLE.
- Reset (async, `srst`=0) forces IDLE immediately, including mid-transaction. All outputs go to 0: `dwb_stb`, `dwb_wre`, `dwb_sel`, `dwb_adr`, `dwb_dto`, `xrdat`, `xrdv`, `xmis`, `xerr`, `xstall`.

## Timing

- Accept at edge 0, then `dwb_stb`=1 from cycle 1.
- Ack sampled at edge k (k≥1) gives `dwb_stb`=0, `xstall`=0 and `xrdv`=1 in cycle k+1.
  - Minimum load latency: 2 cycles from accept edge to `xrdv`.
- Back-to-back requests: the next accept can occur in the cycle `xrdv`/store completion is visible, so there is one dead bus cycle between transactions.
- `xmis` appears 1 cycle after the accept edge. `xerr` appears in the cycle after the TOUT-th unacked BUSY cycle.
- Pulse outputs are high for exactly one cycle.

## Test plan

- XLEN=32 LB at `dadr`=0x1003, `dwb_dti`=0x80FF_FF00, ack at first BUSY cycle:
  - `dwb_sel`=0x8, `dwb_adr`=0x400;
  - `xrdat`=0xFFFF_FF80 two cycles after accept;
  - LBU at the same address gives 0x0000_0080.
- XLEN=32 SH at 0x2002, `ddat`=0x1234_ABCD:
  - `dwb_sel`=0xC, `dwb_dto`=0xABCD_ABCD, `dwb_wre`=1;
  - no `xrdv`.
- XLEN=64 LW at 0x...04, `dwb_dti`=0x8765_4321_0000_0000:
  - `dwb_sel`=0xF0, `xrdat`=0xFFFF_FFFF_8765_4321;
  - LWU gives 0x0000_0000_8765_4321.
- Illegal accesses:
  - LH at 0x1001 gives a one-cycle `xmis`, `dwb_stb` stays 0;
  - XLEN=32 LD at 0x0 gives `xmis`.
- TOUT=4 with ack never asserted:
  - `dwb_stb` high for exactly 4 cycles, then `xerr` pulse, then IDLE;
  - with ack on the 4th cycle instead: `xrdv`, no `xerr`.
- `srst` low while BUSY:
  - `dwb_stb` and `xstall` drop asynchronously;
  - after release, a late ack is ignored and a new LW completes normally.
